// File: rtl/uncached_write_buffer.sv
// uncached_write_buffer
//   Posted-write FIFO on the uncached data path, between the core's
//   uncached dbus request and the DBus-to-CBus converter. Stores complete to
//   the core as soon as they are buffered and drain to the converter in
//   order. Loads are forwarded only while the buffer is empty, so no load
//   can overtake an older store.
//
// Ports:
//   clk     clock
//   resetn  asynchronous active-low reset
//   dreq    upstream uncached request {valid, addr, size, strobe, data}
//   dresp   upstream response {addr_ok, data_ok, data}
//   odreq   request to the DBus-to-CBus converter
//   odresp  response from the converter
//   empty   no buffered store and no access in flight

package uncached_write_buffer_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

endpackage

module uncached_write_buffer
    import uncached_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output dbus_req_t  odreq,
    input  dbus_resp_t odresp,
    output logic       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW + 1)'(1);

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        LOAD
    } state_t;

    state_t        state;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    entry_t        mem [DEPTH];

    logic is_store;
    logic is_load;
    logic full;
    logic accept;
    logic pop;
    logic fwd_load;

    assign is_store = dreq.valid && (dreq.strobe != '0);
    assign is_load  = dreq.valid && (dreq.strobe == '0);
    assign full     = (count == CNT_FULL);

    // Gating with resetn keeps both interfaces quiet while reset is held,
    // even if the core still drives a request.
    assign accept   = resetn && is_store && !full && (state != LOAD);
    assign pop      = (count != '0) && (state != LOAD) && odresp.data_ok;
    assign fwd_load = resetn &&
                      (((state == IDLE) && (count == '0) && is_load) ||
                       (state == LOAD));

    assign empty = (count == '0) && (state == IDLE);

    always_comb begin
        odreq = '0;
        dresp = '0;
        if (fwd_load) begin
            // Only path where odresp reaches dresp combinationally.
            odreq = dreq;
            dresp = odresp;
        end else begin
            if (count != '0) begin
                odreq.valid  = 1'b1;
                odreq.addr   = mem[head].addr;
                odreq.size   = mem[head].size;
                odreq.strobe = mem[head].strobe;
                odreq.data   = mem[head].data;
            end
            if (accept) begin
                dresp.addr_ok = 1'b1;
                dresp.data_ok = 1'b1;
            end
        end
    end

    // Entry storage carries no reset; only head/tail/count define validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[tail] <= '{addr:   dreq.addr,
                           size:   dreq.size,
                           strobe: dreq.strobe,
                           data:   dreq.data};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept) tail <= tail + 1'b1;
            if (pop)    head <= head + 1'b1;

            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (accept)
                        state <= DRAIN;
                    else if (fwd_load && odresp.addr_ok && !odresp.data_ok)
                        state <= LOAD;
                end
                DRAIN: begin
                    if (pop && !accept && (count == CNT_ONE))
                        state <= IDLE;
                end
                LOAD: begin
                    if (odresp.data_ok)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uncached_write_buffer.sv
// tb_uncached_write_buffer
//   Directed testbench for uncached_write_buffer: single store, fill to full,
//   load ordering behind a store, pointer wrap-around, simultaneous
//   enqueue/pop and asynchronous reset during a drain.

module tb_uncached_write_buffer;
    import uncached_write_buffer_pkg::*;

    logic       clk;
    logic       resetn;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    dbus_req_t  odreq;
    dbus_resp_t odresp;
    logic       empty;

    int n_cmp;
    int n_bad;

    uncached_write_buffer #(.DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .dreq   (dreq),
        .dresp  (dresp),
        .odreq  (odreq),
        .odresp (odresp),
        .empty  (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d);
        dreq.valid  = 1'b1;
        dreq.addr   = a;
        dreq.size   = 3'd2;
        dreq.strobe = 4'hF;
        dreq.data   = d;
    endtask

    task automatic drive_load(input logic [31:0] a);
        dreq.valid  = 1'b1;
        dreq.addr   = a;
        dreq.size   = 3'd2;
        dreq.strobe = 4'h0;
        dreq.data   = '0;
    endtask

    task automatic drive_idle();
        dreq = '0;
    endtask

    task automatic pop_resp(input logic ok);
        odresp         = '0;
        odresp.data_ok = ok;
    endtask

    dbus_req_t   exp_req;
    logic [31:0] q[$];
    int          model_cnt;
    int          sent;
    int          popped;
    logic        do_pop;
    logic        acc_exp;

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        resetn = 1'b0;
        dreq   = '0;
        odresp = '0;

        // Reset state
        #1;
        check("rst_odreq", odreq, '0);
        check("rst_dresp", dresp, '0);
        check("rst_empty", empty, 1'b1);
        check("rst_count", dut.count, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Single store
        drive_store(32'h1FD0_03F8, 32'h41);
        #1;
        check("st_addr_ok", dresp.addr_ok, 1'b1);
        check("st_data_ok", dresp.data_ok, 1'b1);
        check("st_rdata",   dresp.data, 32'h0);
        check("st_no_early", odreq.valid, 1'b0);
        tick();
        drive_idle();
        #1;
        exp_req = '{valid: 1'b1, addr: 32'h1FD0_03F8, size: 3'd2,
                    strobe: 4'hF, data: 32'h41};
        check("st_odreq", odreq, exp_req);
        check("st_busy", empty, 1'b0);
        tick();
        check("st_hold", odreq, exp_req);
        pop_resp(1'b1);
        #1;
        check("st_hold_ok", odreq, exp_req);
        tick();
        pop_resp(1'b0);
        #1;
        check("st_empty", empty, 1'b1);
        check("st_idle_odreq", odreq.valid, 1'b0);

        // Fill to full, no full-bypass
        for (int i = 1; i <= 5; i++) begin
            drive_store(32'h1000 + 32'(4 * i), 32'(i));
            #1;
            check("fill_acc", dresp.addr_ok, (i <= 4));
            if (i <= 4) tick();
        end
        check("fill_head", odreq.data, 32'd1);
        pop_resp(1'b1);
        #1;
        check("fill_nobypass", dresp.addr_ok, 1'b0);
        tick();
        pop_resp(1'b0);
        #1;
        check("fill_late_acc", dresp.addr_ok, 1'b1);
        check("fill_cnt3", dut.count, 3);
        tick();
        drive_idle();
        #1;
        check("fill_cnt4", dut.count, 4);
        for (int k = 2; k <= 5; k++) begin
            check("fill_valid", odreq.valid, 1'b1);
            check("fill_order", odreq.data, 32'(k));
            pop_resp(1'b1);
            tick();
            pop_resp(1'b0);
            #1;
        end
        check("fill_empty", empty, 1'b1);

        // Load behind a store; converter takes three cycles per access
        drive_store(32'h1FAF_F000, 32'hAA);
        #1;
        check("ld_st_acc", dresp.addr_ok, 1'b1);
        tick();
        drive_load(32'h1FAF_F000);
        #1;
        check("ld_blocked", dresp.addr_ok, 1'b0);
        check("ld_st_first", odreq.strobe, 4'hF);
        tick();
        check("ld_st_data", odreq.data, 32'hAA);
        tick();
        odresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h5555_5555};
        #1;
        check("ld_no_comb_a", dresp.addr_ok, 1'b0);
        check("ld_no_comb_d", dresp.data, 32'h0);
        tick();
        odresp = '0;
        #1;
        check("ld_fwd_valid", odreq.valid, 1'b1);
        check("ld_fwd_strobe", odreq.strobe, 4'h0);
        check("ld_fwd_addr", odreq.addr, 32'h1FAF_F000);
        tick();
        check("ld_wait", dresp.addr_ok, 1'b0);
        tick();
        odresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
        #1;
        check("ld_addr_ok", dresp.addr_ok, 1'b1);
        check("ld_no_data", dresp.data_ok, 1'b0);
        tick();
        odresp = '0;
        #1;
        check("ld_in_load", empty, 1'b0);
        check("ld_load_odreq", odreq.valid, 1'b1);
        odresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'hDEAD_BEEF};
        #1;
        check("ld_data_ok", dresp.data_ok, 1'b1);
        check("ld_rdata", dresp.data, 32'hDEAD_BEEF);
        tick();
        drive_idle();
        odresp = '0;
        #1;
        check("ld_done", empty, 1'b1);

        // Load whose addr_ok and data_ok coincide stays in IDLE
        drive_load(32'h1FAF_F004);
        odresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h1234};
        #1;
        check("ld1_rdata", dresp.data, 32'h1234);
        tick();
        drive_idle();
        odresp = '0;
        #1;
        check("ld1_idle", empty, 1'b1);

        // Wrap-around with interleaved pops
        model_cnt = 0;
        sent      = 0;
        popped    = 0;
        for (int cyc = 0; cyc < 60 && popped < 10; cyc++) begin
            do_pop = (model_cnt > 0) && ((cyc % 2 == 1) || (sent == 10));
            if (sent < 10) drive_store(32'h2000 + 32'(4 * sent), 32'h100 + 32'(sent));
            else drive_idle();
            pop_resp(do_pop);
            #1;
            acc_exp = (sent < 10) && (model_cnt < 4);
            if (sent < 10) check("wrap_acc", dresp.addr_ok, acc_exp);
            if (do_pop) check("wrap_order", odreq.data, q[0]);
            if (acc_exp) begin
                q.push_back(32'h100 + 32'(sent));
                sent++;
            end
            if (do_pop) begin
                void'(q.pop_front());
                popped++;
            end
            model_cnt = model_cnt + (acc_exp ? 1 : 0) - (do_pop ? 1 : 0);
            tick();
            check("wrap_cnt", dut.count, model_cnt);
        end
        pop_resp(1'b0);
        drive_idle();
        check("wrap_all_popped", popped, 10);
        #1;
        check("wrap_empty", empty, 1'b1);

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h3000 + 32'(4 * i), 32'h31 + 32'(i));
            #1;
            check("rd_acc", dresp.addr_ok, 1'b1);
            tick();
        end
        drive_store(32'h3100, 32'h99);
        #1;
        check("rd_cnt3", dut.count, 3);
        resetn = 1'b0;
        #1;
        check("rd_odreq", odreq, '0);
        check("rd_dresp", dresp, '0);
        check("rd_empty", empty, 1'b1);
        tick();
        drive_idle();
        resetn = 1'b1;
        drive_store(32'h3200, 32'h77);
        #1;
        check("rd_new_acc", dresp.addr_ok, 1'b1);
        tick();
        drive_idle();
        #1;
        check("rd_new_data", odreq.data, 32'h77);
        check("rd_new_addr", odreq.addr, 32'h3200);
        pop_resp(1'b1);
        tick();
        pop_resp(1'b0);
        #1;
        check("rd_new_empty", empty, 1'b1);
        check("rd_head", dut.head, 1);
        check("rd_tail", dut.tail, 1);

        // Simultaneous enqueue and pop at count == 2
        drive_store(32'h4000, 32'h51);
        tick();
        drive_store(32'h4004, 32'h52);
        tick();
        drive_store(32'h4008, 32'h53);
        pop_resp(1'b1);
        #1;
        check("sim_cnt_before", dut.count, 2);
        check("sim_head_data", odreq.data, 32'h51);
        check("sim_acc", dresp.addr_ok, 1'b1);
        tick();
        drive_idle();
        pop_resp(1'b0);
        #1;
        check("sim_cnt", dut.count, 2);
        check("sim_head", dut.head, 2);
        check("sim_tail", dut.tail, 0);
        for (int k = 0; k < 2; k++) begin
            check("sim_order", odreq.data, 32'h52 + 32'(k));
            pop_resp(1'b1);
            tick();
            pop_resp(1'b0);
            #1;
        end
        check("sim_empty", empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
